// File: rtl/tw_sar_if.sv
// Handshake/bus bundle between the SAR sequencer and its surroundings.
// The slave modport is the sequencer side; the master modport drives requests and the comparator.
interface tw_sar_if #(
  parameter int unsigned NBITS = 8
);
  logic             ena;
  logic             start;
  logic             cont;
  logic             cmp_in;
  logic             sample_en;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;
  logic             valid;

  modport slave (
    input  ena, start, cont, cmp_in,
    output sample_en, dac_code, busy, done, result, valid
  );

  modport master (
    output ena, start, cont, cmp_in,
    input  sample_en, dac_code, busy, done, result, valid
  );
endinterface

// File: rtl/tw_sar_ctrl.sv
// Successive-approximation sequencer: sample phase, binary-search trial codes, result capture.
// Optional macro TW_SAR_CMP_SYNC_EN adds a 2-flop comparator synchronizer and two extra hold cycles per bit.
module tw_sar_ctrl #(
  parameter int unsigned NBITS         = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  tw_sar_if.slave  bus
);

  localparam int unsigned IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned CW = 5;
  localparam logic [NBITS-1:0] MSB_CODE = {1'b1, {(NBITS-1){1'b0}}};

  logic cmp_d;

`ifdef TW_SAR_CMP_SYNC_EN
  localparam int unsigned HOLD = SETTLE_CYCLES + 2;
  logic [1:0] sync_q;

  // Two-stage synchronizer; the extra hold cycles let it flush the previous trial's decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.cmp_in};
  end
  assign cmp_d = sync_q[1];
`else
  localparam int unsigned HOLD = SETTLE_CYCLES;
  assign cmp_d = bus.cmp_in;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [NBITS-1:0] code;
  logic [NBITS-1:0] decided;
  logic [NBITS-1:0] next_trial;

  // Current trial with bit i resolved by the comparator, and the next trial with bit i-1 set.
  always_comb begin
    decided          = bus.dac_code;
    decided[bit_idx] = cmp_d;
    next_trial       = decided;
    if (bit_idx != '0) next_trial[bit_idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= IW'(NBITS - 1);
      code          <= '0;
      bus.sample_en <= 1'b0;
      bus.dac_code  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.valid     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (!bus.ena) begin
        // Abort: partial conversion discarded, result/valid kept.
        state         <= IDLE;
        cnt           <= '0;
        bit_idx       <= IW'(NBITS - 1);
        bus.sample_en <= 1'b0;
        bus.dac_code  <= '0;
        bus.busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state         <= SAMPLE;
              cnt           <= '0;
              bus.sample_en <= 1'b1;
              bus.dac_code  <= '0;
              bus.busy      <= 1'b1;
            end
          end
          SAMPLE: begin
            if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
              state         <= SETTLE;
              cnt           <= '0;
              bit_idx       <= IW'(NBITS - 1);
              bus.sample_en <= 1'b0;
              bus.dac_code  <= MSB_CODE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SETTLE: begin
            if (cnt == CW'(HOLD - 1)) begin
              cnt <= '0;
              if (bit_idx == '0) begin
                state        <= DONE;
                code         <= decided;
                bus.dac_code <= '0;
              end else begin
                bit_idx      <= bit_idx - IW'(1);
                bus.dac_code <= next_trial;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            bus.result <= code;
            bus.done   <= 1'b1;
            bus.valid  <= 1'b1;
            bit_idx    <= IW'(NBITS - 1);
            cnt        <= '0;
            if (bus.cont) begin
              state         <= SAMPLE;
              bus.sample_en <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/tw_sar_ctrl.md
Name: tw_sar_ctrl

Overview:
Successive-approximation sequencer for the TinyWhisper analog front end. It drives the sample switch and capacitive-DAC trial code on the analog macro, and reads back the analog comparator decision. It produces one NBITS-bit conversion per start request, or back-to-back conversions in continuous mode. It sits between the digital pins (ui_in/uo_out/uio) and the analog block wired to ua[5:0].

Parameters:
NBITS, 8, conversion resolution; also the width of dac_code and result.
SAMPLE_CYCLES, 4, number of cycles sample_en is held high (legal range 1..15).
SETTLE_CYCLES, 2, number of cycles each trial code is held before the comparator is sampled (legal range 1..15).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
ena  input  1  block enable; low forces abort to IDLE
start  input  1  conversion request, level-sampled in IDLE
cont  input  1  continuous mode; sampled in DONE
cmp_in  input  1  comparator output; 1 = Vin >= Vdac
sample_en  output  1  closes the sampling switch (track phase)
dac_code  output  NBITS  trial code driven to the capacitive DAC
busy  output  1  high in SAMPLE, SETTLE and DONE
done  output  1  one-cycle pulse when result updates
result  output  NBITS  last completed conversion
valid  output  1  high once any conversion has completed since reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sample_en=0, dac_code=0, busy=0, done=0, result=0, valid=0, bit index=NBITS-1, counters=0.
- All outputs are registered.
- IDLE: sample_en=0, dac_code=0. On a rising edge with ena=1 and start=1, go to SAMPLE.
- SAMPLE: sample_en=1, dac_code=0 for exactly SAMPLE_CYCLES cycles, then SETTLE with bit index i=NBITS-1.
- SETTLE, bit i: dac_code = {decided bits above i, 1 at position i, zeros below}. The code is held SETTLE_CYCLES cycles. On the last cycle's edge, cmp_in is captured: 1 keeps bit i, 0 clears it.
  - If i>0: decrement i and reload the settle counter.
  - If i=0: go to DONE.
- DONE (one cycle): result <= decided code, done=1, valid=1, dac_code=0.
  - Next state is SAMPLE if cont=1 and ena=1; otherwise IDLE.
- Latency: the start-capture edge is edge 0. done is high after edge 1+SAMPLE_CYCLES+NBITS*SETTLE_CYCLES (defaults: edge 21, high for one cycle).
- Continuous-mode period: 1+SAMPLE_CYCLES+NBITS*SETTLE_CYCLES cycles (defaults: 21).
- start while busy: ignored, no queuing. start held high in IDLE retriggers each time IDLE is reached.
- ena=0 in any state: synchronous return to IDLE on the next edge.
  - sample_en=0, dac_code=0, busy=0, done=0.
  - result and valid are held; the partial conversion is discarded.
- cont and start are both ignored while ena=0.
- Reset mid-conversion: immediate async clear to the reset values above; no done pulse.
- cmp_in is used only on decision edges; it is don't-care at all other times.

Optional Feature:
Macro TW_SAR_CMP_SYNC_EN.
- Defined: cmp_in passes through a 2-flop synchronizer before the decision logic. Each bit's hold time becomes SETTLE_CYCLES+2 cycles, so the synchronized sample reflects cmp_in from the settled code. Latency becomes 1+SAMPLE_CYCLES+NBITS*(SETTLE_CYCLES+2) (defaults: edge 37).
- Undefined: cmp_in is used directly as described above. Latency is unchanged.

Test Plan:
- Comparator model cmp_in=(vin_code>=dac_code), vin_code=0xA5, pulse start: sample_en high for 4 cycles. Trial codes observed are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. done pulses at edge 21; result=0xA5, valid=1.
- Boundary inputs vin_code=0x00 and vin_code=0xFF: result=0x00 and 0xFF respectively, each with a single done pulse at edge 21.
- cont=1, vin_code=0x3C, single start: done pulses at edges 21, 42, 63, each with result=0x3C. Dropping cont before a DONE cycle returns the block to IDLE with busy=0.
- Extra start pulses at edges 5 and 12 during a conversion: ignored. Exactly one done, at edge 21.
- ena=0 at edge 10 after a prior result of 0x11: busy=0, dac_code=0, sample_en=0 from edge 11, no done, result stays 0x11.
- rst_n pulsed low mid-SETTLE: all outputs at reset values immediately, without waiting for an edge. A fresh start then converts normally with the edge-21 latency.
